// File: rtl/sd_cic_decimator.sv
// 3rd-order CIC decimator for a 2-bit sigma-delta bitstream, with a valid/ready PCM output.
// Optional SD_CIC_DROPCNT_EN adds a saturating drop_cnt output next to the sticky overflow flag.
module sd_cic_decimator #(
  parameter int LOG2_DECIM = 4,
  parameter int ACC_W      = 3 + 3 * LOG2_DECIM
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_en,
  input  logic [1:0]              sd_in,
  output logic signed [ACC_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_settled,
  output logic                    overflow,
  input  logic                    clr_ovf
`ifdef SD_CIC_DROPCNT_EN
  ,
  output logic [15:0]             drop_cnt
`endif
);

  logic signed [ACC_W-1:0] x;
  logic signed [ACC_W-1:0] i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
  logic signed [ACC_W-1:0] d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
  logic signed [ACC_W-1:0] c1, c2, c3;
  logic [LOG2_DECIM-1:0]   phase_q, phase_d;
  logic                    dec_strb_q, dec_strb_d;
  logic signed [ACC_W-1:0] out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    settled_q, settled_d;
  logic                    ovf_q, ovf_d;
  logic [1:0]              load_cnt_q, load_cnt_d;
  logic                    drop;

  always_comb begin
    case (sd_in)
      2'b11:   x = {{(ACC_W-2){1'b0}}, 2'b10};
      2'b00:   x = {{(ACC_W-2){1'b1}}, 2'b10};
      default: x = '0;
    endcase

    i1_d       = i1_q;
    i2_d       = i2_q;
    i3_d       = i3_q;
    phase_d    = phase_q;
    dec_strb_d = 1'b0;
    if (in_en) begin
      i1_d       = i1_q + x;
      i2_d       = i2_q + i1_q;
      i3_d       = i3_q + i2_q;
      phase_d    = phase_q + 1'b1;
      dec_strb_d = (phase_q == '1);
    end

    // Comb stage reads the integrator value already updated by the strobe-setting edge.
    c1 = i3_q - d1_q;
    c2 = c1 - d2_q;
    c3 = c2 - d3_q;

    d1_d = d1_q;
    d2_d = d2_q;
    d3_d = d3_q;
    if (dec_strb_q) begin
      d1_d = i3_q;
      d2_d = c1;
      d3_d = c2;
    end

    drop        = dec_strb_q && out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (dec_strb_q) begin
      if (!out_valid_q || out_ready) begin
        out_data_d  = c3;
        out_valid_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // Settling counts every offered result, dropped ones included.
    load_cnt_d = load_cnt_q;
    settled_d  = settled_q;
    if (dec_strb_q) begin
      if (load_cnt_q == 2'd3) settled_d  = 1'b1;
      else                    load_cnt_d = load_cnt_q + 2'd1;
    end

    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
    else              ovf_d = ovf_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i1_q        <= '0;
      i2_q        <= '0;
      i3_q        <= '0;
      d1_q        <= '0;
      d2_q        <= '0;
      d3_q        <= '0;
      phase_q     <= '0;
      dec_strb_q  <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      settled_q   <= 1'b0;
      ovf_q       <= 1'b0;
      load_cnt_q  <= '0;
    end else begin
      i1_q        <= i1_d;
      i2_q        <= i2_d;
      i3_q        <= i3_d;
      d1_q        <= d1_d;
      d2_q        <= d2_d;
      d3_q        <= d3_d;
      phase_q     <= phase_d;
      dec_strb_q  <= dec_strb_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      settled_q   <= settled_d;
      ovf_q       <= ovf_d;
      load_cnt_q  <= load_cnt_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_settled = settled_q;
  assign overflow    = ovf_q;

`ifdef SD_CIC_DROPCNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // A clear coinciding with a drop leaves exactly that one drop counted.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (clr_ovf)                         drop_cnt_d = drop ? 16'd1 : 16'd0;
    else if (drop && drop_cnt_q != '1)   drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_sd_cic_decimator.sv
// Bench for sd_cic_decimator: table of constant-input runs, randomized run against a
// closed-form CIC model, and timed sequences for backpressure and mid-frame reset.
module tb_sd_cic_decimator;
  localparam int LOG2_DECIM = 4;
  localparam int R          = 16;
  localparam int ACC_W      = 15;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_en = 1'b0;
  logic [1:0]       sd_in = 2'b00;
  logic             out_ready = 1'b1;
  logic             clr_ovf = 1'b0;
  logic [ACC_W-1:0] out_data;
  logic             out_valid;
  logic             out_settled;
  logic             overflow;
`ifdef SD_CIC_DROPCNT_EN
  logic [15:0]      drop_cnt;
`endif

  int   n_chk = 0;
  int   n_fail = 0;
  int   xs[$];
  int   w_data[$];
  int   w_set[$];
  int   w_edge[$];

  typedef struct {
    int         mode;        // 0: in_en=1, 1: in_en toggling
    logic [1:0] pat;
    int         steady;
    int         first_edge;
    int         period;
  } vec_t;
  vec_t tbl[6];

  always #5 clk = ~clk;

  sd_cic_decimator #(.LOG2_DECIM(LOG2_DECIM), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset(reset), .in_en(in_en), .sd_in(sd_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_settled(out_settled), .overflow(overflow), .clr_ovf(clr_ovf)
`ifdef SD_CIC_DROPCNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int sdata();
    logic signed [ACC_W-1:0] s;
    s = out_data;
    return int'(s);
  endfunction

  // Third integrator after n samples: sum of x[m]*C(n-1-m,2).
  function automatic longint i3_at(input int n);
    longint s = 0;
    for (int m = 0; m < n - 2; m++)
      s += longint'(xs[m]) * longint'(n - 1 - m) * longint'(n - 2 - m) / 2;
    return s;
  endfunction

  // Word k (1-based) is the third difference of i3 sampled every R inputs, wrapped to ACC_W.
  function automatic int model_word(input int k);
    longint y;
    logic signed [ACC_W-1:0] t;
    y = i3_at(k * R) - 3 * i3_at((k - 1) * R) + 3 * i3_at((k - 2) * R) - i3_at((k - 3) * R);
    t = y[ACC_W-1:0];
    return int'(t);
  endfunction

  task automatic do_reset(input bit chk);
    @(negedge clk);
    reset = 1'b0; in_en = 1'b0; sd_in = 2'b00; clr_ovf = 1'b0; out_ready = 1'b1;
    #1;
    if (chk) begin
      check("rst_data", sdata(), 0);
      check("rst_valid", out_valid, 0);
      check("rst_settled", out_settled, 0);
      check("rst_ovf", overflow, 0);
    end
    @(negedge clk);
    reset = 1'b1;
    xs.delete(); w_data.delete(); w_set.delete(); w_edge.delete();
  endtask

  task automatic drive(input int mode, input logic [1:0] pat, input int edge_no);
    if (mode == 0)      in_en = 1'b1;
    else if (mode == 1) in_en = (edge_no % 2 == 1);
    else                in_en = ($urandom_range(0, 3) != 0);
    sd_in = (mode == 2) ? 2'($urandom_range(0, 3)) : pat;
    if (in_en) xs.push_back((sd_in[0] ? 1 : -1) + (sd_in[1] ? 1 : -1));
  endtask

  task automatic run(input int mode, input logic [1:0] pat, input int nwords);
    int e = 0;
    int limit = nwords * R * 8 + 64;
    while (w_data.size() < nwords && e < limit) begin
      drive(mode, pat, e + 1);
      @(negedge clk);
      e++;
      if (out_valid && out_ready) begin
        w_data.push_back(sdata());
        w_set.push_back(int'(out_settled));
        w_edge.push_back(e);
      end
    end
    if (w_data.size() < nwords) check("word_timeout", w_data.size(), nwords);
    in_en = 1'b0;
  endtask

  task automatic check_words(input bit use_model, input bit chk_steady, input int steady,
                             input int first_edge, input int period);
    if (w_data.size() == 0) return;
    if (first_edge > 0) check("first_edge", w_edge[0], first_edge);
    for (int k = 0; k < w_data.size(); k++) begin
      if (use_model) check($sformatf("model_w%0d", k + 1), w_data[k], model_word(k + 1));
      if (chk_steady && k >= 3) check($sformatf("steady_w%0d", k + 1), w_data[k], steady);
      check($sformatf("settled_w%0d", k + 1), w_set[k], (k >= 3) ? 1 : 0);
      if (period > 0 && k > 0) check("period", w_edge[k] - w_edge[k-1], period);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, 2'b11,  8192, 17, 16};
    tbl[1] = '{0, 2'b00, -8192, 17, 16};
    tbl[2] = '{0, 2'b01,     0, 17, 16};
    tbl[3] = '{0, 2'b10,     0, 17, 16};
    tbl[4] = '{1, 2'b11,  8192, 32, 32};
    tbl[5] = '{1, 2'b00, -8192, 32, 32};

    for (int v = 0; v < 6; v++) begin
      do_reset(v == 0);
      run(tbl[v].mode, tbl[v].pat, 8);
      check_words(1'b1, 1'b1, tbl[v].steady, tbl[v].first_edge, tbl[v].period);
      check("tbl_ovf", overflow, 0);
    end

    // Randomized bitstream and enable against the closed-form model.
    do_reset(1'b0);
    run(2, 2'b00, 40);
    check_words(1'b1, 1'b0, 0, 0, 0);

    // Long constant run: integrators wrap many times, settled words stay exact.
    do_reset(1'b0);
    run(0, 2'b11, 1500);
    check_words(1'b0, 1'b1, 8192, 17, 16);
    check("long_ovf", overflow, 0);

    // Backpressure across three decimation periods, clear coinciding with a drop.
    do_reset(1'b0);
    out_ready = 1'b0; in_en = 1'b1; sd_in = 2'b11;
    for (int e = 1; e <= 66; e++) begin
      clr_ovf = (e == 33) || (e == 50);
      @(negedge clk);
      if (e == 17) begin
        check("bp_valid17", out_valid, 1);
        check("bp_data17", sdata(), 1120);
        check("bp_ovf17", overflow, 0);
      end
      if (e == 33) begin
        check("bp_ovf_clr_drop", overflow, 1);
`ifdef SD_CIC_DROPCNT_EN
        check("bp_dcnt33", drop_cnt, 1);
`endif
      end
      if (e == 49) begin
        check("bp_ovf49", overflow, 1);
        check("bp_frozen", sdata(), 1120);
        check("bp_valid49", out_valid, 1);
        check("bp_settled49", out_settled, 0);
`ifdef SD_CIC_DROPCNT_EN
        check("bp_dcnt49", drop_cnt, 2);
`endif
      end
      if (e == 50) begin
        check("bp_ovf_cleared", overflow, 0);
`ifdef SD_CIC_DROPCNT_EN
        check("bp_dcnt_cleared", drop_cnt, 0);
`endif
        out_ready = 1'b1;
      end
      if (e == 51) check("bp_accept_clears", out_valid, 0);
      if (e == 65) begin
        check("bp_settled65", out_settled, 1);
        check("bp_data65", sdata(), 8192);
      end
    end
    clr_ovf = 1'b0;

    // Reset pulsed low mid-frame with a held word and overflow set.
    do_reset(1'b0);
    out_ready = 1'b0; in_en = 1'b1; sd_in = 2'b11;
    for (int e = 1; e <= 40; e++) @(negedge clk);
    check("pre_rst_valid", out_valid, 1);
    check("pre_rst_ovf", overflow, 1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_data", sdata(), 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ovf", overflow, 0);
    check("mid_rst_settled", out_settled, 0);
    @(negedge clk);
    reset = 1'b1; out_ready = 1'b1;
    for (int e = 1; e <= 65; e++) begin
      @(negedge clk);
      if (e == 16) check("rr_valid16", out_valid, 0);
      if (e == 17) begin
        check("rr_valid17", out_valid, 1);
        check("rr_data17", sdata(), 1120);
      end
      if (e == 33 || e == 49) check($sformatf("rr_settled%0d", e), out_settled, 0);
      if (e == 65) check("rr_settled65", out_settled, 1);
    end
    in_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
